kpn_adder_node: RTL and testbench

Parametrised Kahn-process-network adder node for the KPN fabric: it buffers tokens arriving on `NUM_IN` input channels in per-channel FIFOs and fires once every channel holds a token. Each firing pops one token per channel, sums them, and offers the result on a registered valid/ready output channel. It supersedes the single-shot combinational 16-bit adder with blocking-read/blocking-write KPN semantics, selectable wrap or saturate arithmetic, and per-token overflow reporting.

---
 rtl/kpn_adder_node.sv | 225 ++++++++++++++++++++++
 tb/tb_kpn_adder_node.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/kpn_adder_node.sv
// -----------------------------------------------------------------------------
// kpn_adder_node
//
// Kahn-process-network adder node. Each of NUM_IN input channels feeds its
// own FIFO. The node fires when every FIFO holds a token and the output
// register is free, or is being drained in the same cycle. A firing pops one
// token per channel, adds them and loads the result into a registered
// valid/ready output stage.
//
// Parameters
//   WIDTH      : token width in bits (unsigned)
//   NUM_IN     : number of input channels (2..8)
//   FIFO_DEPTH : per-channel FIFO depth (power of two, >= 2)
//   SATURATE   : 0 = wrap modulo 2^WIDTH, 1 = clamp to 2^WIDTH-1
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   in_data    : channel k token at bits [k*WIDTH +: WIDTH]
//   in_valid   : per-channel token present
//   in_ready   : per-channel FIFO not full (low while reset is high)
//   out_data   : result token (registered)
//   out_ovf    : true sum exceeded 2^WIDTH-1 (registered, qualified by out_valid)
//   out_valid  : result token present (registered)
//   out_ready  : downstream accepts the result
//   fire_count : number of firings since reset, wraps at 2^16
// -----------------------------------------------------------------------------
module kpn_adder_node #(
    parameter int WIDTH      = 16,
    parameter int NUM_IN     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SATURATE   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             fire_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Wide enough that NUM_IN maximal tokens never truncate.
    localparam int SUM_W = WIDTH + $clog2(NUM_IN);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Per-channel FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem_q  [NUM_IN][FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q [NUM_IN];
    logic [PTR_W-1:0] rptr_q [NUM_IN];
    logic [CNT_W-1:0] cnt_q  [NUM_IN];

    // Output stage
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             out_ovf_q;
    logic             out_ovf_d;
    logic [15:0]      fire_count_q;
    logic [15:0]      fire_count_d;

    // Combinational helpers
    logic [NUM_IN-1:0] push_s;
    logic [NUM_IN-1:0] nonempty_s;
    logic [WIDTH-1:0]  head_s [NUM_IN];
    logic              fire_s;
    logic [SUM_W-1:0]  sum_s;
    logic              sum_ovf_s;
    logic [WIDTH-1:0]  result_s;

    // Channel status: readiness comes only from registered occupancy so that
    // out_ready never reaches in_ready combinationally.
    always_comb begin
        in_ready   = '0;
        push_s     = '0;
        nonempty_s = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            in_ready[k]   = (!reset) && (cnt_q[k] != CNT_FULL);
            push_s[k]     = in_valid[k] && in_ready[k];
            nonempty_s[k] = (cnt_q[k] != '0);
            head_s[k]     = mem_q[k][rptr_q[k]];
        end
    end

    // Fire when every channel has a token and the output slot is free or
    // being drained this cycle.
    always_comb begin
        if ((&nonempty_s) && ((state_q == ST_EMPTY) || out_ready)) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Full-precision sum of the FIFO heads, then wrap or clamp.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            sum_s = sum_s + SUM_W'(head_s[k]);
        end
        sum_ovf_s = |sum_s[SUM_W-1:WIDTH];
        if ((SATURATE != 0) && sum_ovf_s) begin
            result_s = {WIDTH{1'b1}};
        end else begin
            result_s = sum_s[WIDTH-1:0];
        end
    end

    // Output FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (fire_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (fire_s) begin
                    state_d = ST_FULL;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Output data path next values: loaded only on a firing, otherwise held.
    always_comb begin
        out_data_d   = out_data_q;
        out_ovf_d    = out_ovf_q;
        fire_count_d = fire_count_q;
        if (fire_s) begin
            out_data_d   = result_s;
            out_ovf_d    = sum_ovf_s;
            fire_count_d = fire_count_q + 16'd1;
        end else begin
            out_data_d   = out_data_q;
            out_ovf_d    = out_ovf_q;
            fire_count_d = fire_count_q;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            out_data_q   <= '0;
            out_ovf_q    <= 1'b0;
            fire_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_ovf_q    <= out_ovf_d;
            fire_count_q <= fire_count_d;
        end
    end

    // FIFO pointers and occupancy; a pop happens on every channel at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_IN; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (push_s[k]) begin
                    wptr_q[k] <= wptr_q[k] + PTR_ONE;
                end else begin
                    wptr_q[k] <= wptr_q[k];
                end
                if (fire_s) begin
                    rptr_q[k] <= rptr_q[k] + PTR_ONE;
                end else begin
                    rptr_q[k] <= rptr_q[k];
                end
                case ({push_s[k], fire_s})
                    2'b10:   cnt_q[k] <= cnt_q[k] + CNT_ONE;
                    2'b01:   cnt_q[k] <= cnt_q[k] - CNT_ONE;
                    default: cnt_q[k] <= cnt_q[k];
                endcase
            end
        end
    end

    // FIFO storage writes; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_IN; k++) begin
            if (push_s[k]) begin
                mem_q[k][wptr_q[k]] <= in_data[k*WIDTH +: WIDTH];
            end else begin
                mem_q[k][wptr_q[k]] <= mem_q[k][wptr_q[k]];
            end
        end
    end

    assign out_valid  = (state_q == ST_FULL);
    assign out_data   = out_data_q;
    assign out_ovf    = out_ovf_q;
    assign fire_count = fire_count_q;

endmodule

// File: tb/tb_kpn_adder_node.sv
// Self-checking bench for kpn_adder_node. Two instances (wrap and saturate,
// three channels) share every input. A queue-based reference model predicts
// readiness, output valid and firing count each cycle and pushes expected
// full-width sums into a scoreboard; a separate monitor pops and compares on
// every output handshake.
module tb_kpn_adder_node;

    localparam int W = 16;
    localparam int N = 3;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic           out_ready;
    logic [N-1:0]   rdy_w, rdy_s;
    logic [W-1:0]   dat_w, dat_s;
    logic           ovf_w, ovf_s, vld_w, vld_s;
    logic [15:0]    fc_w, fc_s;

    always #5 clk = ~clk;

    kpn_adder_node #(.WIDTH(W), .NUM_IN(N), .FIFO_DEPTH(D), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_w), .out_data(dat_w), .out_ovf(ovf_w), .out_valid(vld_w),
        .out_ready(out_ready), .fire_count(fc_w));

    kpn_adder_node #(.WIDTH(W), .NUM_IN(N), .FIFO_DEPTH(D), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_s), .out_data(dat_s), .out_ovf(ovf_s), .out_valid(vld_s),
        .out_ready(out_ready), .fire_count(fc_s));

    typedef logic [W-1:0] tok_q_t[$];

    int          checks   = 0;
    int          failures = 0;
    tok_q_t      chq[N];
    logic [17:0] expq[$];
    logic        model_ov = 1'b0;
    logic [15:0] model_fc = 16'd0;
    logic [N-1:0] last_acc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check current state, then
    // advance the reference model to what the next rising edge should produce.
    task automatic cycle(input logic rst, input logic [N-1:0] v,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic ordy);
        logic [W-1:0] d[N];
        logic [N-1:0] acc;
        logic         fire;
        logic [17:0]  sum;
        @(negedge clk);
        reset     = rst;
        in_valid  = v;
        in_data   = {c, b, a};
        out_ready = ordy;
        #1;
        d[0] = a; d[1] = b; d[2] = c;
        for (int k = 0; k < N; k++) begin
            chk("in_ready_wrap", 32'(rdy_w[k]), 32'(!rst && (chq[k].size() < D)));
            chk("in_ready_sat",  32'(rdy_s[k]), 32'(!rst && (chq[k].size() < D)));
        end
        chk("out_valid_wrap", 32'(vld_w), 32'(model_ov));
        chk("out_valid_sat",  32'(vld_s), 32'(model_ov));
        chk("fire_count_wrap", 32'(fc_w), 32'(model_fc));
        chk("fire_count_sat",  32'(fc_s), 32'(model_fc));
        acc = '0;
        if (rst) begin
            for (int k = 0; k < N; k++) chq[k].delete();
            expq.delete();
            model_ov = 1'b0;
            model_fc = 16'd0;
        end else begin
            fire = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (chq[k].size() == 0) fire = 1'b0;
                acc[k] = v[k] && (chq[k].size() < D);
            end
            if (model_ov && !ordy) fire = 1'b0;
            if (fire) begin
                sum = 18'd0;
                for (int k = 0; k < N; k++) sum = sum + 18'(chq[k].pop_front());
                expq.push_back(sum);
                model_ov = 1'b1;
                model_fc = model_fc + 16'd1;
            end else if (model_ov && ordy) begin
                model_ov = 1'b0;
            end
            for (int k = 0; k < N; k++) if (acc[k]) chq[k].push_back(d[k]);
        end
        last_acc = acc;
    endtask

    // Monitor: scoreboard pops on each output handshake; held outputs must
    // not change while out_ready is low.
    initial begin : monitor
        logic        hold_prev;
        logic [W-1:0] held_w, held_s;
        logic [17:0] s;
        hold_prev = 1'b0;
        held_w = '0;
        held_s = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev && vld_w) begin
                    chk("hold_data_wrap", 32'(dat_w), 32'(held_w));
                    chk("hold_data_sat",  32'(dat_s), 32'(held_s));
                end
                if (vld_w && out_ready) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        s = expq.pop_front();
                        chk("data_wrap", 32'(dat_w), 32'(s[15:0]));
                        chk("ovf_wrap",  32'(ovf_w), 32'(s > 18'h0FFFF));
                        chk("data_sat",  32'(dat_s), (s > 18'h0FFFF) ? 32'h0000FFFF : 32'(s[15:0]));
                        chk("ovf_sat",   32'(ovf_s), 32'(s > 18'h0FFFF));
                    end
                end
                hold_prev = vld_w && !out_ready;
                held_w    = dat_w;
                held_s    = dat_s;
            end
        end
    end

    initial begin : driver
        logic [W-1:0] cur[N];
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state while reset is held
        cycle(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0);
        chk("reset_data_wrap", 32'(dat_w), 32'd0);
        chk("reset_ovf_wrap",  32'(ovf_w), 32'd0);
        chk("reset_data_sat",  32'(dat_s), 32'd0);

        // Basic add, result two edges after the push
        cycle(1'b0, 3'b111, 16'h1234, 16'h0101, 16'h0000, 1'b1);
        repeat (3) cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);

        // Blocking read: ch0 alone never fires
        cycle(1'b0, 3'b001, 16'd1, 16'h0, 16'h0, 1'b1);
        cycle(1'b0, 3'b001, 16'd2, 16'h0, 16'h0, 1'b1);
        cycle(1'b0, 3'b001, 16'd3, 16'h0, 16'h0, 1'b1);
        repeat (3) cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
        cycle(1'b0, 3'b110, 16'h0, 16'd10, 16'd0, 1'b1);
        cycle(1'b0, 3'b110, 16'h0, 16'd20, 16'd0, 1'b1);
        cycle(1'b0, 3'b110, 16'h0, 16'd30, 16'd0, 1'b1);
        repeat (4) cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);

        // Backpressure: 5 tokens fit (4 buffered + 1 held), the 6th waits
        for (int k = 0; k < N; k++) cur[k] = W'(16'h0100 * (k + 1));
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 3'b111, cur[0], cur[1], cur[2], 1'b0);
            for (int k = 0; k < N; k++) if (last_acc[k]) cur[k] = cur[k] + 16'd1;
        end
        repeat (8) cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);

        // Overflow: wrap vs clamp, then a non-overflowing triple
        cycle(1'b0, 3'b111, 16'hFFFF, 16'hFFFF, 16'h0002, 1'b1);
        cycle(1'b0, 3'b111, 16'h0001, 16'h0001, 16'h0001, 1'b1);
        repeat (3) cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);

        // Random traffic; a sender holds its token until accepted
        for (int k = 0; k < N; k++) cur[k] = W'($urandom);
        for (int i = 0; i < 3000; i++) begin
            cycle(1'b0, N'($urandom), cur[0], cur[1], cur[2], 1'($urandom_range(0, 2) != 0));
            for (int k = 0; k < N; k++) if (last_acc[k]) cur[k] = W'($urandom);
        end
        repeat (8) cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);

        // Reset mid-stream: output pending and two tokens left on ch0
        cycle(1'b0, 3'b111, 16'd100, 16'd200, 16'd300, 1'b0);
        cycle(1'b0, 3'b001, 16'd1, 16'h0, 16'h0, 1'b0);
        cycle(1'b0, 3'b001, 16'd2, 16'h0, 16'h0, 1'b0);
        cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0);
        chk("pending_before_reset", 32'(vld_w), 32'd1);
        cycle(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0);
        cycle(1'b0, 3'b111, 16'h0005, 16'h0007, 16'h0000, 1'b1);
        repeat (4) cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);

        // Firing counter wraps after 65536 firings; data stream keeps checking
        for (int i = 0; i < 65540; i++) begin
            cycle(1'b0, 3'b111, W'($urandom), W'($urandom), W'($urandom), 1'b1);
        end

        // Drain with a bounded budget
        for (int i = 0; i < 40 && (expq.size() != 0 || model_ov); i++) begin
            cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
        end
        repeat (2) cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        chk("final_out_valid", 32'(vld_w), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
